interrupt_sequencer: RTL

// - Sits directly upstream of the control unit, on the IR load path.
// - Samples NMI (edge), IRQ (level, I-masked) and reset; at each instruction boundary it either passes the fetched opcode
//   to IR or injects BRK ($00) with the matching vector.
// - Also runs the power-on/reset hold and the $FFFC reset vector sequence.

---
 rtl/interrupt_sequencer_if.sv | 27 ++
 rtl/interrupt_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/interrupt_sequencer_if.sv
// Bus between the control unit and the interrupt sequencer on the IR load path.
// The control side drives requests and the opcode; the sequencer answers with IR and vector info.
interface interrupt_sequencer_if;
  logic        nmi_n;
  logic        irq_n;
  logic [7:0]  P_in;
  logic        fetch_req;
  logic [7:0]  mem_data;
  logic        int_ack;
  logic [7:0]  IR_out;
  logic        injected;
  logic        pc_inc_inh;
  logic        brk_b;
  logic        rst_seq;
  logic [15:0] vect_addr;
  logic        cpu_hold;

  modport master (
    output nmi_n, irq_n, P_in, fetch_req, mem_data, int_ack,
    input  IR_out, injected, pc_inc_inh, brk_b, rst_seq, vect_addr, cpu_hold
  );

  modport slave (
    input  nmi_n, irq_n, P_in, fetch_req, mem_data, int_ack,
    output IR_out, injected, pc_inc_inh, brk_b, rst_seq, vect_addr, cpu_hold
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// At each instruction boundary either passes the fetched opcode to IR or injects BRK ($00)
// with the NMI/IRQ vector; also runs the reset hold and the $FFFC reset vector sequence.
module interrupt_sequencer #(
  parameter int RST_CYCLES  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_sequencer_if.slave bus
);
  localparam int CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

  typedef enum logic [1:0] {S_HOLD, S_VEC_RST, S_RUN, S_INT} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       counter;
  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   nmi_s_prev;
  logic                   nmi_latch;
  logic                   brk_q;
  logic                   rst_seq_q;
  logic                   cpu_hold_q;
  logic [15:0]            vect_q;
  logic                   inject;
  logic                   unused_p_bits;

  wire nmi_s    = nmi_sync[SYNC_STAGES-1];
  wire irq_s    = irq_sync[SYNC_STAGES-1];
  wire nmi_edge = nmi_s_prev & ~nmi_s;
  wire irq_eff  = ~irq_s & ~bus.P_in[2];

  assign unused_p_bits = ^{bus.P_in[7:3], bus.P_in[1:0]};

  // Decisions use the registered nmi_latch, so an edge seen in a fetch cycle waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOLD;
      counter    <= CNT_W'(RST_CYCLES);
      nmi_sync   <= '1;
      irq_sync   <= '1;
      nmi_s_prev <= 1'b1;
      nmi_latch  <= 1'b0;
      cpu_hold_q <= 1'b1;
      brk_q      <= 1'b0;
      rst_seq_q  <= 1'b1;
      vect_q     <= RESET_VECTOR;
    end else begin
      nmi_sync   <= {nmi_sync[SYNC_STAGES-2:0], bus.nmi_n};
      irq_sync   <= {irq_sync[SYNC_STAGES-2:0], bus.irq_n};
      nmi_s_prev <= nmi_s;
      nmi_latch  <= nmi_latch | nmi_edge;
      case (state)
        S_HOLD: begin
          if (counter <= CNT_W'(1)) begin
            state      <= S_VEC_RST;
            counter    <= '0;
            cpu_hold_q <= 1'b0;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        S_VEC_RST: begin
          if (bus.int_ack) begin
            state     <= S_RUN;
            rst_seq_q <= 1'b0;
            nmi_latch <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.fetch_req) begin
            if (nmi_latch) begin
              state  <= S_INT;
              brk_q  <= 1'b0;
              vect_q <= NMI_VECTOR;
            end else if (irq_eff) begin
              state  <= S_INT;
              brk_q  <= 1'b0;
              vect_q <= IRQ_VECTOR;
            end else if (bus.mem_data == 8'h00) begin
              state  <= S_INT;
              brk_q  <= 1'b1;
              vect_q <= IRQ_VECTOR;
            end
          end
        end
        S_INT: begin
          // A late NMI hijacks an IRQ/BRK sequence until the vector is acknowledged.
          vect_q <= nmi_latch ? NMI_VECTOR : IRQ_VECTOR;
          if (bus.int_ack) begin
            state <= S_RUN;
            if (vect_q == NMI_VECTOR) nmi_latch <= nmi_edge;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

  always_comb begin
    inject = 1'b0;
    case (state)
      S_VEC_RST: inject = bus.fetch_req;
      S_RUN:     inject = bus.fetch_req & (nmi_latch | irq_eff);
      default:   inject = 1'b0;
    endcase
  end

  assign bus.IR_out     = (inject || state == S_HOLD) ? 8'h00 : bus.mem_data;
  assign bus.injected   = inject;
  assign bus.pc_inc_inh = inject;
  assign bus.brk_b      = brk_q;
  assign bus.rst_seq    = rst_seq_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.vect_addr  = vect_q;
endmodule
